// File: rtl/register_list_sequencer.sv
// Load/store-multiple register-list sequencer: latches a bitmask and issues one
// register address per accepted handshake, ascending or descending.
module register_list_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic                descending,
  input  logic                next,
  output logic                reg_valid,
  output logic [ADDR_W-1:0]   reg_address,
  output logic [ADDR_W:0]     xfer_index,
  output logic                first,
  output logic                last,
  output logic [ADDR_W:0]     reg_count,
  output logic                busy,
  output logic                done,
  output logic                empty
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]          state_reg;
  logic [NUM_REGS-1:0] pending_reg;
  logic                dir_reg;
  logic [ADDR_W-1:0]   reg_address_reg;
  logic [ADDR_W:0]     xfer_index_reg;
  logic [ADDR_W:0]     reg_count_reg;
  logic                reg_valid_reg;
  logic                first_reg;
  logic                last_reg;

  logic [NUM_REGS-1:0] remaining;
  logic [ADDR_W:0]     list_count;

  // Priority encoder: lowest set bit when ascending, highest when descending.
  function automatic logic [ADDR_W-1:0] pick(input logic [NUM_REGS-1:0] mask,
                                             input logic desc);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (desc) begin
        if (mask[i]) idx = ADDR_W'(i);
      end else if (mask[NUM_REGS-1-i]) begin
        idx = ADDR_W'(NUM_REGS-1-i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    list_count = '0;
    for (int i = 0; i < NUM_REGS; i++)
      list_count = list_count + (ADDR_W+1)'(reg_list[i]);
  end

  // Pending mask with the register being accepted this cycle removed.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_remaining
      assign remaining[gi] = pending_reg[gi] & (reg_address_reg != ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      pending_reg     <= '0;
      dir_reg         <= 1'b0;
      reg_address_reg <= '0;
      xfer_index_reg  <= '0;
      reg_count_reg   <= '0;
      reg_valid_reg   <= 1'b0;
      first_reg       <= 1'b0;
      last_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pending_reg   <= reg_list;
            dir_reg       <= descending;
            reg_count_reg <= list_count;
            if (reg_list == '0) begin
              state_reg <= FINISH;
            end else begin
              state_reg       <= ISSUE;
              reg_address_reg <= pick(reg_list, descending);
              xfer_index_reg  <= '0;
              reg_valid_reg   <= 1'b1;
              first_reg       <= 1'b1;
              last_reg        <= (list_count == (ADDR_W+1)'(1));
            end
          end
        end
        ISSUE: begin
          if (next) begin
            pending_reg <= remaining;
            if (|remaining) begin
              reg_address_reg <= pick(remaining, dir_reg);
              xfer_index_reg  <= xfer_index_reg + (ADDR_W+1)'(1);
              first_reg       <= 1'b0;
              last_reg        <= (xfer_index_reg + (ADDR_W+1)'(2) == reg_count_reg);
            end else begin
              reg_valid_reg <= 1'b0;
              first_reg     <= 1'b0;
              last_reg      <= 1'b0;
              state_reg     <= FINISH;
            end
          end
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign reg_valid   = reg_valid_reg;
  assign reg_address = reg_address_reg;
  assign xfer_index  = xfer_index_reg;
  assign first       = first_reg;
  assign last        = last_reg;
  assign reg_count   = reg_count_reg;
  assign busy        = (state_reg == ISSUE);
  assign done        = (state_reg == FINISH);
  assign empty       = done & (reg_count_reg == '0);

endmodule
